// File: rtl/game_sprite_mover_if.sv
// game_sprite_mover_if: load/status bundle between a sprite controller and game_sprite_mover.
interface game_sprite_mover_if #(
    parameter int X_WIDTH  = 10,
    parameter int Y_WIDTH  = 10,
    parameter int DX_WIDTH = 2,
    parameter int DY_WIDTH = 2
);
    logic                sprite_write;
    logic [X_WIDTH-1:0]  sprite_write_x;
    logic [Y_WIDTH-1:0]  sprite_write_y;
    logic [DX_WIDTH-1:0] sprite_write_dx;
    logic [DY_WIDTH-1:0] sprite_write_dy;
    logic [1:0]          sprite_write_mode;
    logic [X_WIDTH-1:0]  sprite_x;
    logic [Y_WIDTH-1:0]  sprite_y;
    logic [DX_WIDTH-1:0] sprite_dx;
    logic [DY_WIDTH-1:0] sprite_dy;
    logic                sprite_moving;
    logic                sprite_edge;
    modport master (
        output sprite_write, sprite_write_x, sprite_write_y, sprite_write_dx, sprite_write_dy, sprite_write_mode,
        input  sprite_x, sprite_y, sprite_dx, sprite_dy, sprite_moving, sprite_edge
    );
    modport slave (
        input  sprite_write, sprite_write_x, sprite_write_y, sprite_write_dx, sprite_write_dy, sprite_write_mode,
        output sprite_x, sprite_y, sprite_dx, sprite_dy, sprite_moving, sprite_edge
    );
endinterface

// File: rtl/game_sprite_mover.sv
// game_sprite_mover: strobed sprite position/velocity engine with wrap, bounce and stop edge modes.
module game_sprite_mover #(
    parameter int X_WIDTH      = 10,
    parameter int Y_WIDTH      = 10,
    parameter int DX_WIDTH     = 2,
    parameter int DY_WIDTH     = 2,
    parameter int STROBE_WIDTH = 20,
    parameter int X_MAX        = 639,
    parameter int Y_MAX        = 479
) (
    input logic                clk,
    input logic                reset,
    game_sprite_mover_if.slave bus
);
    typedef enum logic {IDLE, MOVING} state_t;
    localparam logic [1:0] WRAP = 2'd0;
    localparam logic [1:0] BOUNCE = 2'd1;
    localparam logic [X_WIDTH-1:0] XMAX = X_WIDTH'(X_MAX);
    localparam logic [Y_WIDTH-1:0] YMAX = Y_WIDTH'(Y_MAX);
    localparam logic signed [X_WIDTH:0] XMAX_S = $signed({1'b0, XMAX});
    localparam logic signed [Y_WIDTH:0] YMAX_S = $signed({1'b0, YMAX});
    localparam logic [DX_WIDTH-1:0] DX_MIN = {1'b1, {(DX_WIDTH-1){1'b0}}};
    localparam logic [DY_WIDTH-1:0] DY_MIN = {1'b1, {(DY_WIDTH-1){1'b0}}};
    state_t                  state_q, state_d;
    logic [X_WIDTH-1:0]      x_q, x_d;
    logic [Y_WIDTH-1:0]      y_q, y_d;
    logic [DX_WIDTH-1:0]     dx_q, dx_d;
    logic [DY_WIDTH-1:0]     dy_q, dy_d;
    logic [1:0]              mode_q, mode_d;
    logic                    edge_q, edge_d;
    logic [STROBE_WIDTH-1:0] cnt_q;
    logic                    strobe;
    logic signed [X_WIDTH:0] nx;
    logic signed [Y_WIDTH:0] ny;
    logic                    x_lo, x_hi, x_edge, y_lo, y_hi, y_edge;
    logic [X_WIDTH-1:0]      x_clamp, x_wrap;
    logic [Y_WIDTH-1:0]      y_clamp, y_wrap;
    logic [DX_WIDTH-1:0]     dx_flip;
    logic [DY_WIDTH-1:0]     dy_flip;

    assign strobe  = &cnt_q;
    assign nx      = $signed({1'b0, x_q}) + $signed({{(X_WIDTH+1-DX_WIDTH){dx_q[DX_WIDTH-1]}}, dx_q});
    assign ny      = $signed({1'b0, y_q}) + $signed({{(Y_WIDTH+1-DY_WIDTH){dy_q[DY_WIDTH-1]}}, dy_q});
    assign x_lo    = nx[X_WIDTH];
    assign y_lo    = ny[Y_WIDTH];
    assign x_hi    = nx > XMAX_S;
    assign y_hi    = ny > YMAX_S;
    assign x_edge  = x_lo | x_hi;
    assign y_edge  = y_lo | y_hi;
    assign x_clamp = x_lo ? '0 : x_hi ? XMAX : nx[X_WIDTH-1:0];
    assign y_clamp = y_lo ? '0 : y_hi ? YMAX : ny[Y_WIDTH-1:0];
    assign x_wrap  = x_lo ? XMAX : x_hi ? '0 : nx[X_WIDTH-1:0];
    assign y_wrap  = y_lo ? YMAX : y_hi ? '0 : ny[Y_WIDTH-1:0];
    // Negating the most-negative speed saturates to the most-positive one
    assign dx_flip = (dx_q == DX_MIN) ? ~DX_MIN : -dx_q;
    assign dy_flip = (dy_q == DY_MIN) ? ~DY_MIN : -dy_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        mode_d  = mode_q;
        edge_d  = 1'b0;
        if (bus.sprite_write) begin
            x_d     = (bus.sprite_write_x > XMAX) ? XMAX : bus.sprite_write_x;
            y_d     = (bus.sprite_write_y > YMAX) ? YMAX : bus.sprite_write_y;
            dx_d    = bus.sprite_write_dx;
            dy_d    = bus.sprite_write_dy;
            mode_d  = bus.sprite_write_mode;
            state_d = (|bus.sprite_write_dx || |bus.sprite_write_dy) ? MOVING : IDLE;
        end else if (strobe && state_q == MOVING) begin
            edge_d = x_edge | y_edge;
            x_d    = (mode_q == WRAP) ? x_wrap : x_clamp;
            y_d    = (mode_q == WRAP) ? y_wrap : y_clamp;
            if (mode_q == BOUNCE) begin
                dx_d = x_edge ? dx_flip : dx_q;
                dy_d = y_edge ? dy_flip : dy_q;
            end else if (mode_q != WRAP && edge_d) begin
                dx_d    = '0;
                dy_d    = '0;
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            mode_q  <= '0;
            edge_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            mode_q  <= mode_d;
            edge_q  <= edge_d;
            cnt_q   <= cnt_q + STROBE_WIDTH'(1);
        end
    end

    assign bus.sprite_x      = x_q;
    assign bus.sprite_y      = y_q;
    assign bus.sprite_dx     = dx_q;
    assign bus.sprite_dy     = dy_q;
    assign bus.sprite_moving = (state_q == MOVING);
    assign bus.sprite_edge   = edge_q;
endmodule

// File: tb/tb_game_sprite_mover.sv
// tb_game_sprite_mover: directed checks of idle, wrap, bounce, stop, write/strobe collision and reset.
module tb_game_sprite_mover;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    int cyc = 0;

    game_sprite_mover_if bus ();
    game_sprite_mover #(.STROBE_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Motion lands on the edge that ends the counter's all-ones cycle: every 16th edge after reset
    task automatic to_strobe();
        tick();
        while (cyc % 16 != 0) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [9:0] x, input logic [9:0] y, input logic [1:0] dx, input logic [1:0] dy, input logic [1:0] m);
        bus.sprite_write      = 1'b1;
        bus.sprite_write_x    = x;
        bus.sprite_write_y    = y;
        bus.sprite_write_dx   = dx;
        bus.sprite_write_dy   = dy;
        bus.sprite_write_mode = m;
        tick();
        bus.sprite_write = 1'b0;
    endtask

    task automatic chk_pos(input string tag, input int x, input int y, input int dx, input int dy, input int mv, input int ed);
        chk({tag, ".x"}, 32'(bus.sprite_x), x);
        chk({tag, ".y"}, 32'(bus.sprite_y), y);
        chk({tag, ".dx"}, 32'(bus.sprite_dx), dx);
        chk({tag, ".dy"}, 32'(bus.sprite_dy), dy);
        chk({tag, ".moving"}, 32'(bus.sprite_moving), mv);
        chk({tag, ".edge"}, 32'(bus.sprite_edge), ed);
    endtask

    initial begin
        bus.sprite_write      = 1'b0;
        bus.sprite_write_x    = '0;
        bus.sprite_write_y    = '0;
        bus.sprite_write_dx   = '0;
        bus.sprite_write_dy   = '0;
        bus.sprite_write_mode = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc = 0;
        chk_pos("reset", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("idle.moving", 32'(bus.sprite_moving), 0);
            chk("idle.edge", 32'(bus.sprite_edge), 0);
        end
        chk_pos("idle_end", 0, 0, 0, 0, 0, 0);
        // Wrap: 638 -> 639 -> 0
        wr(10'd638, 10'd10, 2'b01, 2'b00, 2'd0);
        chk_pos("wrap_load", 638, 10, 1, 0, 1, 0);
        to_strobe();
        chk_pos("wrap_s1", 639, 10, 1, 0, 1, 0);
        to_strobe();
        chk_pos("wrap_s2", 0, 10, 1, 0, 1, 1);
        tick();
        chk("wrap_edge_end", 32'(bus.sprite_edge), 0);
        // Bounce: x hits low edge first, then y hits high edge
        wr(10'd1, 10'd478, 2'b10, 2'b01, 2'd1);
        to_strobe();
        chk_pos("bounce_s1", 0, 479, 1, 1, 1, 1);
        tick();
        chk("bounce_edge_end", 32'(bus.sprite_edge), 0);
        to_strobe();
        chk_pos("bounce_s2", 1, 479, 1, 3, 1, 1);
        // Stop
        wr(10'd639, 10'd100, 2'b01, 2'b00, 2'd2);
        to_strobe();
        chk_pos("stop_s1", 639, 100, 0, 0, 0, 1);
        tick();
        chk("stop_edge_end", 32'(bus.sprite_edge), 0);
        to_strobe();
        chk_pos("stop_idle", 639, 100, 0, 0, 0, 0);
        // Collision: write held during the strobe cycle, with out-of-range load clamped
        while (cyc % 16 != 15) tick();
        wr(10'd1000, 10'd900, 2'b01, 2'b01, 2'd1);
        chk_pos("collide", 639, 479, 1, 1, 1, 0);
        to_strobe();
        chk_pos("collide_s1", 639, 479, 3, 3, 1, 1);
        tick();
        // Wrap off the low edges on both axes
        wr(10'd0, 10'd0, 2'b11, 2'b11, 2'd0);
        to_strobe();
        chk_pos("wrap_low", 639, 479, 3, 3, 1, 1);
        // Reset asserted between clock edges while moving
        tick();
        tick();
        chk("pre_reset.moving", 32'(bus.sprite_moving), 1);
        reset = 1'b1;
        #2;
        chk_pos("async_reset", 0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        cyc = 0;
        wr(10'd5, 10'd5, 2'b01, 2'b01, 2'd0);
        while (cyc < 15) tick();
        chk_pos("resume_pre", 5, 5, 1, 1, 1, 0);
        tick();
        chk_pos("resume_s1", 6, 6, 1, 1, 1, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/game_sprite_mover.md
GAME_SPRITE_MOVER -- requirements
Module: game_sprite_mover

Interface
REQ-001 SHALL have parameter X_WIDTH, default 10, X coordinate width in bits.
REQ-002 SHALL have parameter Y_WIDTH, default 10, Y coordinate width in bits.
REQ-003 SHALL have parameter DX_WIDTH, default 2, signed X speed width (2..X_WIDTH-1).
REQ-004 SHALL have parameter DY_WIDTH, default 2, signed Y speed width (2..Y_WIDTH-1).
REQ-005 SHALL have parameter STROBE_WIDTH, default 20, motion-strobe divider width in bits.
REQ-006 SHALL have parameter X_MAX, default 639, and Y_MAX, default 479, the inclusive playfield limits.
REQ-007 SHALL have port clk, input, 1, sole clock.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port sprite_write, input, 1, load strobe.
REQ-010 SHALL have ports sprite_write_x/_y, input, X_WIDTH/Y_WIDTH, load position.
REQ-011 SHALL have ports sprite_write_dx/_dy, input, DX_WIDTH/DY_WIDTH, signed load speed.
REQ-012 SHALL have port sprite_write_mode, input, 2, edge mode: 0 wrap, 1 bounce, 2 stop, 3 reserved (treated as stop).
REQ-013 SHALL have ports sprite_x/_y, output, X_WIDTH/Y_WIDTH, current position.
REQ-014 SHALL have ports sprite_dx/_dy, output, DX_WIDTH/DY_WIDTH, current speed.
REQ-015 SHALL have port sprite_moving, output, 1, high in state MOVING.
REQ-016 SHALL have port sprite_edge, output, 1, one-cycle pulse on any edge event.

Function
REQ-017 SHALL contain a free-running STROBE_WIDTH-bit counter; strobe is high the cycle the counter equals all ones, then counter wraps to 0.
REQ-018 SHALL implement states IDLE and MOVING; sprite_write with nonzero dx or dy -> MOVING, with both zero -> IDLE.
REQ-019 SHALL on sprite_write register x, y, dx, dy, mode next cycle; x above X_MAX loaded as X_MAX, y above Y_MAX loaded as Y_MAX.
REQ-020 SHALL give sprite_write priority over strobe in the same cycle; no motion applied that cycle; strobe counter keeps running.
REQ-021 SHALL on strobe in MOVING compute nx = x + sign-extended dx, ny = y + sign-extended dy, in one-bit-wider signed arithmetic; update registered 1 cycle after strobe.
REQ-022 SHALL, in IDLE, ignore strobe; outputs hold.
REQ-023 SHALL treat nx < 0 or nx > X_MAX as an X edge event (likewise Y with Y_MAX); axes handled independently.
REQ-024 SHALL in wrap mode set x to X_MAX when nx < 0 and to 0 when nx > X_MAX (no remainder carry); same for y.
REQ-025 SHALL in bounce mode clamp x to 0 or X_MAX and negate dx; negation of most-negative dx yields most-positive value; same for y.
REQ-026 SHALL in stop mode clamp position as bounce, set dx and dy both to 0, and enter IDLE.
REQ-027 SHALL pulse sprite_edge high for exactly the cycle the edge-affected position is registered; otherwise low.
REQ-028 SHALL keep outputs purely registered (no combinational path from inputs to outputs).

Reset
REQ-029 SHALL on reset asynchronously clear x, y, dx, dy, mode, strobe counter, sprite_edge to 0 and enter IDLE, including mid-motion.
REQ-030 SHALL resume operation on first clk edge after reset deasserts; no strobe before counter reaches all ones again.

Verification (STROBE_WIDTH=4 for sims)
REQ-031 SHALL cover reset then idle: all outputs 0, sprite_moving 0 for 100 cycles despite strobes.
REQ-032 SHALL cover wrap: write x=638,y=10,dx=+1,dy=0,mode 0 -> after strobes x=639, then x=0 with sprite_edge pulse, y stays 10.
REQ-033 SHALL cover bounce: write x=1,y=478,dx=-2,dy=+1,mode 1 -> next strobe x=0,dx=+1 (clamped max of -(-2)), y=479, dy=+1; following strobe y edge: y=479, dy=-1, edge pulse.
REQ-034 SHALL cover stop: write x=639,dx=+1,mode 2 -> strobe: x=639, dx=dy=0, sprite_moving 0, edge pulse once.
REQ-035 SHALL cover write/strobe collision and clamp: write x=1000,y=900 coincident with strobe -> x=639,y=479, no motion that cycle.
REQ-036 SHALL cover reset asserted mid-motion between clock edges -> outputs 0 immediately, IDLE.
